// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Lets the instruction-fetch port (I) and the data-memory port (D) share one
//   single-port, fixed-latency memory. Only one access is in flight at a time.
//   When both ports request in the same cycle, the port that did not win the
//   previous grant wins this one. Each completed access is reported with a
//   one-cycle ack pulse, and read data is held in a per-port register.
//
//   Sequence per access: IDLE (arbitrate) -> ISSUE (MemEn strobe) ->
//   WAIT (MEM_LAT cycles) -> RESP (ack) -> IDLE.
//   Throughput is one access every MEM_LAT+3 cycles.
//
// Ports
//   Clk, Rst           clock (rising edge); asynchronous active-high reset
//   IReq/IAddr         fetch request, held until IAck
//   IAck/IRdata        fetch-done pulse; fetched word, held until the next I completion
//   DReq/DWe/DAddr/DWdata  data request (DWe=1 store, DWe=0 load), held until DAck
//   DAck/DRdata        data-done pulse; load word, held until the next D load
//   MemEn/MemWe        one-cycle access strobe; write enable qualified by MemEn
//   MemAddr/MemWdata   access address and write data, stable from ISSUE through RESP
//   MemRdata           read data, valid MEM_LAT cycles after MemEn
//   StallI/StallD      combinational holds for the hazard unit: Req & ~Ack
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,   // legal range 1..15
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              IReq,
  input  logic [ADDR_W-1:0] IAddr,
  output logic              IAck,
  output logic [DATA_W-1:0] IRdata,
  input  logic              DReq,
  input  logic              DWe,
  input  logic [ADDR_W-1:0] DAddr,
  input  logic [DATA_W-1:0] DWdata,
  output logic              DAck,
  output logic [DATA_W-1:0] DRdata,
  output logic              MemEn,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  output logic              StallI,
  output logic              StallD
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic       OWN_I = 1'b0;
  localparam logic       OWN_D = 1'b1;
  localparam logic [3:0] LAT   = 4'(MEM_LAT);

  state_t            state;
  state_t            state_nxt;
  logic              owner;
  logic              last_grant;
  logic              we_q;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] irdata_q;
  logic [DATA_W-1:0] drdata_q;
  logic              any_req;
  logic              grant_d;
  logic              lat_done;

  // D wins when it is the only requester, or on a tie when I had the last grant.
  assign any_req  = IReq | DReq;
  assign grant_d  = DReq & (~IReq | (last_grant == OWN_I));
  assign lat_done = (cnt == LAT);

  assign MemAddr  = addr_q;
  assign MemWdata = wdata_q;
  assign IRdata   = irdata_q;
  assign DRdata   = drdata_q;

  // Stalls stay purely combinational so they follow the requests even in reset.
  assign StallI = IReq & ~IAck;
  assign StallD = DReq & ~DAck;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    MemEn     = 1'b0;
    MemWe     = 1'b0;
    IAck      = 1'b0;
    DAck      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        MemEn     = 1'b1;
        MemWe     = we_q;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (lat_done) state_nxt = RESP;
      end
      RESP: begin
        // Requests are not looked at here; a re-request is arbitrated in IDLE.
        IAck      = (owner == OWN_I);
        DAck      = (owner == OWN_D);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      owner      <= OWN_I;
      last_grant <= OWN_I;
      we_q       <= 1'b0;
      cnt        <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      irdata_q   <= '0;
      drdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Grant edge: everything the access needs is captured here, so later
          // changes on the request ports cannot disturb the access in flight.
          if (any_req) begin
            owner      <= grant_d;
            last_grant <= grant_d;
            addr_q     <= grant_d ? DAddr : IAddr;
            wdata_q    <= DWdata;
            we_q       <= grant_d & DWe;
          end
        end
        ISSUE: begin
          cnt <= 4'd1;
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (lat_done) begin
            if (owner == OWN_I) begin
              irdata_q <= MemRdata;
            end else if (!we_q) begin
              drdata_q <= MemRdata;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
